mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register of the 5-stage MIPS core; feeds the write-back mux stage directly.
//  Performs data-memory loads/stores (byte/half/word, signed/unsigned) on an internal word-addressed RAM.
//  Registers ALU result, load data, PC+4 and control bits for WB; supports stall, flush and a debug read port.
// PARAMETERS
//  DEPTH     256  data-memory depth in 32-bit words (power of 2)
//  ADDR_W    8    word-address width, = log2(DEPTH)
// PORTS
//  Clk           in   1   rising-edge clock
//  Reset         in   1   synchronous, active-high reset
//  Stall         in   1   hold MEM/WB register, suppress memory write
//  Flush         in   1   load bubble into MEM/WB, suppress memory write
//  ALUResult_M   in   32  byte address / ALU result from EX/MEM
//  WriteData_M   in   32  store data (rt)
//  PCAdder_M     in   32  PC+4 (JAL link value)
//  MemRead_M     in   1   load enable
//  MemWrite_M    in   1   store enable
//  MemSize_M     in   2   00 byte, 01 half, 11 word (10 treated as word)
//  MemSigned_M   in   1   1 = sign-extend load, 0 = zero-extend
//  MemToReg_M    in   2   WB select, passed through
//  RegWrite_M    in   1   register-file write enable, passed through
//  WriteReg_M    in   5   destination register, passed through
//  DbgAddr       in   ADDR_W  debug word address (combinational read)
//  DbgData       out  32  raw memory word at DbgAddr
//  ALUResult_WB  out  32  registered ALUResult_M
//  MemReadData_WB out 32  registered, extended load data
//  PCAdder_WB    out  32  registered PCAdder_M
//  MemToReg_WB   out  2   registered MemToReg_M
//  RegWrite_WB   out  1   registered RegWrite_M (0 on bubble)
//  WriteReg_WB   out  5   registered WriteReg_M
//  MisAlign_WB   out  1   registered misalignment flag (only with ALIGN_CHECK_EN, else tied 0)
// BEHAVIOUR
//  - Word index = ALUResult_M[ADDR_W+1:2]; upper bits ignored (wrap modulo DEPTH).
//  - Load: memory read combinational; lane select by addr[1:0] (byte) or addr[1] (half); extend per MemSigned_M;
//    result registered -> 1-cycle latency to WB. MemRead_M=0 -> MemReadData_WB loads 0.
//  - Store: byte-enables byte 0001<<addr[1:0], half 0011<<{addr[1],1'b0}, word 1111; data replicated to lanes;
//    written at rising edge when MemWrite_M & !Stall & !Flush & !Reset. Load next cycle sees new data.
//  - MemRead_M & MemWrite_M both 1: store performed, load data still captured (pre-write value).
//  - Priority Reset > Flush > Stall > normal update.
//  - Reset: all *_WB outputs 0 (MemToReg_WB=00, RegWrite_WB=0); memory contents NOT cleared.
//  - Flush: MEM/WB loads bubble: all *_WB outputs 0; no store.
//  - Stall: all *_WB hold; no store (store completes on the unstalled cycle, exactly once).
//  - DbgData unaffected by Stall/Flush; reflects writes from the previous edge.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is misaligned -> store suppressed,
//   load data 0, RegWrite_WB forced 0, MisAlign_WB=1 for that WB cycle.
//  Not defined: low address bits forced to natural alignment (half clears bit0, word clears [1:0]);
//   access performed; MisAlign_WB tied 0.
// STRUCTURE
//  Shared package mem_pkg: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b11;
//   MEMTOREG_MEM=2'b00, MEMTOREG_PC=2'b01, MEMTOREG_ALU=2'b10.
//  One sub-module: load_store_align (combinational: byte-enables, store-lane replication,
//   load lane extract/extension, misalign detect). RAM array and MEM/WB register in top.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> MemReadData_WB=0xDEADBEEF one cycle after load in MEM.
//  2 SB 0x80 @0x21, LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; other bytes of word 8 unchanged.
//  3 SH 0x8001 @0x22, LH -> 0xFFFF8001, LHU -> 0x00008001; DbgAddr=8 -> DbgData[31:16]=0x8001.
//  4 SW with Stall=1 for 3 cycles then 0 -> exactly one write; *_WB held during stall; Flush -> RegWrite_WB=0, no write.
//  5 Reset asserted mid-stream -> next edge all *_WB=0; previously stored word still readable via DbgData.
//  6 LW @0x13: with ALIGN_CHECK_EN -> MisAlign_WB=1, RegWrite_WB=0; without -> reads word @0x10.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, write-back select codes
// and the MEM/WB pipeline register layout.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE     = 2'b00;
  localparam logic [1:0] MEM_HALF     = 2'b01;
  localparam logic [1:0] MEM_WORD     = 2'b11;

  localparam logic [1:0] MEMTOREG_MEM = 2'b00;
  localparam logic [1:0] MEMTOREG_PC  = 2'b01;
  localparam logic [1:0] MEMTOREG_ALU = 2'b10;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [1:0]  memtoreg;
    logic        regwrite;
    logic [4:0]  writereg;
    logic        misalign;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '{
    alu:      32'h0000_0000,
    rdata:    32'h0000_0000,
    pc:       32'h0000_0000,
    memtoreg: 2'b00,
    regwrite: 1'b0,
    writereg: 5'd0,
    misalign: 1'b0
  };

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for loads and stores. With ALIGN_CHECK_EN defined,
// unaligned half/word accesses are flagged; otherwise the address is forced aligned.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [3:0]  byte_en,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [1:0]  eff_lo_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [3:0]  be_s;
  logic [31:0] ld_s;

  // Effective lane offset and misalignment detection
  always_comb begin
    eff_lo_s = addr_lo;
    misalign = 1'b0;
`ifdef ALIGN_CHECK_EN
    case (size)
      MEM_BYTE: misalign = 1'b0;
      MEM_HALF: misalign = addr_lo[0];
      default:  misalign = (addr_lo != 2'b00);
    endcase
`else
    case (size)
      MEM_BYTE: eff_lo_s = addr_lo;
      MEM_HALF: eff_lo_s = {addr_lo[1], 1'b0};
      default:  eff_lo_s = 2'b00;
    endcase
`endif
  end

  // Lane extraction, extension and store replication
  always_comb begin
    byte_s      = mem_word[{eff_lo_s, 3'b000} +: 8];
    half_s      = eff_lo_s[1] ? mem_word[31:16] : mem_word[15:0];
    be_s        = 4'b1111;
    store_lanes = store_data;
    ld_s        = mem_word;
    case (size)
      MEM_BYTE: begin
        be_s        = 4'b0001 << eff_lo_s;
        store_lanes = {4{store_data[7:0]}};
        ld_s        = {{24{is_signed & byte_s[7]}}, byte_s};
      end
      MEM_HALF: begin
        be_s        = 4'b0011 << {eff_lo_s[1], 1'b0};
        store_lanes = {2{store_data[15:0]}};
        ld_s        = {{16{is_signed & half_s[15]}}, half_s};
      end
      default: begin
        be_s        = 4'b1111;
        store_lanes = store_data;
        ld_s        = mem_word;
      end
    endcase
  end

  assign byte_en   = misalign ? 4'b0000 : be_s;
  assign load_data = misalign ? 32'h0000_0000 : ld_s;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with internal word-addressed data RAM and the MEM/WB register.
// Optional feature macro: ALIGN_CHECK_EN (trap misaligned half/word accesses).
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [31:0]       ALUResult_M,
  input  logic [31:0]       WriteData_M,
  input  logic [31:0]       PCAdder_M,
  input  logic              MemRead_M,
  input  logic              MemWrite_M,
  input  logic [1:0]        MemSize_M,
  input  logic              MemSigned_M,
  input  logic [1:0]        MemToReg_M,
  input  logic              RegWrite_M,
  input  logic [4:0]        WriteReg_M,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [31:0]       DbgData,
  output logic [31:0]       ALUResult_WB,
  output logic [31:0]       MemReadData_WB,
  output logic [31:0]       PCAdder_WB,
  output logic [1:0]        MemToReg_WB,
  output logic              RegWrite_WB,
  output logic [4:0]        WriteReg_WB,
  output logic              MisAlign_WB
);

  logic [31:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] widx_s;
  logic [31:0]       rword_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       lanes_s;
  logic [31:0]       load_s;
  logic              mis_raw_s;
  logic              misalign_s;
  logic              wr_en_s;
  memwb_t            memwb_s;
  memwb_t            memwb_r;

  // Upper address bits are dropped so accesses wrap modulo DEPTH
  assign widx_s  = ALUResult_M[ADDR_W+1:2];
  assign rword_s = mem_r[widx_s];
  assign DbgData = mem_r[DbgAddr];

  load_store_align u_align (
    .addr_lo     (ALUResult_M[1:0]),
    .size        (MemSize_M),
    .is_signed   (MemSigned_M),
    .store_data  (WriteData_M),
    .mem_word    (rword_s),
    .byte_en     (byte_en_s),
    .store_lanes (lanes_s),
    .load_data   (load_s),
    .misalign    (mis_raw_s)
  );

  assign misalign_s = (MemRead_M | MemWrite_M) & mis_raw_s;
  assign wr_en_s    = MemWrite_M & ~Stall & ~Flush & ~Reset & ~misalign_s;

  // Byte-enabled store into the data RAM; contents survive reset
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && byte_en_s[i]) begin
        mem_r[widx_s][8*i +: 8] <= lanes_s[8*i +: 8];
      end
    end
  end

  // Next MEM/WB contents for an unstalled, unflushed cycle
  always_comb begin
    memwb_s          = MEMWB_BUBBLE;
    memwb_s.alu      = ALUResult_M;
    memwb_s.rdata    = (MemRead_M && !misalign_s) ? load_s : 32'h0000_0000;
    memwb_s.pc       = PCAdder_M;
    memwb_s.memtoreg = MemToReg_M;
    memwb_s.regwrite = RegWrite_M & ~misalign_s;
    memwb_s.writereg = WriteReg_M;
    memwb_s.misalign = misalign_s;
  end

  // MEM/WB register: Reset > Flush > Stall > update
  always_ff @(posedge Clk) begin
    if (Reset) begin
      memwb_r <= MEMWB_BUBBLE;
    end else if (Flush) begin
      memwb_r <= MEMWB_BUBBLE;
    end else if (Stall) begin
      memwb_r <= memwb_r;
    end else begin
      memwb_r <= memwb_s;
    end
  end

  assign ALUResult_WB   = memwb_r.alu;
  assign MemReadData_WB = memwb_r.rdata;
  assign PCAdder_WB     = memwb_r.pc;
  assign MemToReg_WB    = memwb_r.memtoreg;
  assign RegWrite_WB    = memwb_r.regwrite;
  assign WriteReg_WB    = memwb_r.writereg;
`ifdef ALIGN_CHECK_EN
  assign MisAlign_WB    = memwb_r.misalign;
`else
  assign MisAlign_WB    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: byte-array memory model plus directed vectors.
// Honours ALIGN_CHECK_EN the same way the design does.
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush;
  logic [31:0] ALUResult_M, WriteData_M, PCAdder_M;
  logic        MemRead_M, MemWrite_M, MemSigned_M, RegWrite_M;
  logic [1:0]  MemSize_M, MemToReg_M;
  logic [4:0]  WriteReg_M;
  logic [7:0]  DbgAddr;
  logic [31:0] DbgData, ALUResult_WB, MemReadData_WB, PCAdder_WB;
  logic [1:0]  MemToReg_WB;
  logic        RegWrite_WB, MisAlign_WB;
  logic [4:0]  WriteReg_WB;

  always #5 Clk = ~Clk;

  mem_wb_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .ALUResult_M(ALUResult_M), .WriteData_M(WriteData_M), .PCAdder_M(PCAdder_M),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .MemSize_M(MemSize_M),
    .MemSigned_M(MemSigned_M), .MemToReg_M(MemToReg_M), .RegWrite_M(RegWrite_M),
    .WriteReg_M(WriteReg_M), .DbgAddr(DbgAddr), .DbgData(DbgData),
    .ALUResult_WB(ALUResult_WB), .MemReadData_WB(MemReadData_WB), .PCAdder_WB(PCAdder_WB),
    .MemToReg_WB(MemToReg_WB), .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
    .MisAlign_WB(MisAlign_WB)
  );

  // Model state: 1 KiB of bytes, little-endian, plus the expected WB contents
  logic [7:0]  mm [1024];
  logic [31:0] e_alu, e_rd, e_pc;
  logic [1:0]  e_mtr;
  logic        e_rw, e_mis;
  logic [4:0]  e_wr;
  int          checks = 0;
  int          failures = 0;
  bit          init_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
  endfunction

  // Predict one clock edge from the current inputs, then compare every output
  task automatic cycle();
    int          a, n;
    logic [31:0] ld;
    logic        mis;
    a   = int'(ALUResult_M[9:0]);
    n   = (MemSize_M == 2'b00) ? 1 : (MemSize_M == 2'b01) ? 2 : 4;
    mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    mis = (MemRead_M || MemWrite_M) && ((a % n) != 0);
`else
    a = a - (a % n);
`endif
    ld = 32'h0;
    for (int i = 0; i < n; i++) ld[8*i +: 8] = mm[(a + i) % 1024];
    if (MemSigned_M && n < 4 && ld[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) ld[i] = 1'b1;
    end
    if (!MemRead_M || mis) ld = 32'h0;
    if (Reset || Flush) begin
      e_alu = 32'h0; e_rd = 32'h0; e_pc = 32'h0; e_mtr = 2'b00;
      e_rw = 1'b0; e_wr = 5'd0; e_mis = 1'b0;
    end else if (!Stall) begin
      e_alu = ALUResult_M; e_rd = ld; e_pc = PCAdder_M; e_mtr = MemToReg_M;
      e_rw = RegWrite_M && !mis; e_wr = WriteReg_M; e_mis = mis;
    end
    if (MemWrite_M && !Stall && !Flush && !Reset && !mis) begin
      for (int i = 0; i < n; i++) mm[a + i] = WriteData_M[8*i +: 8];
    end
    @(posedge Clk);
    #1;
    chk("alu_wb", ALUResult_WB, e_alu);
    chk("rdata_wb", MemReadData_WB, e_rd);
    chk("pc_wb", PCAdder_WB, e_pc);
    chk("memtoreg_wb", {30'd0, MemToReg_WB}, {30'd0, e_mtr});
    chk("regwrite_wb", {31'd0, RegWrite_WB}, {31'd0, e_rw});
    chk("writereg_wb", {27'd0, WriteReg_WB}, {27'd0, e_wr});
    chk("misalign_wb", {31'd0, MisAlign_WB}, {31'd0, e_mis});
    if (init_done) chk("dbgdata", DbgData, mword(int'(DbgAddr)));
  endtask

  task automatic op(input logic r, input logic w, input logic [1:0] sz, input logic sg,
                    input logic [31:0] addr, input logic [31:0] wd);
    MemRead_M   = r;
    MemWrite_M  = w;
    MemSize_M   = sz;
    MemSigned_M = sg;
    ALUResult_M = addr;
    WriteData_M = wd;
    PCAdder_M   = addr + 32'h0000_1004;
    MemToReg_M  = r ? 2'b00 : 2'b10;
    RegWrite_M  = r;
    WriteReg_M  = addr[4:0] ^ 5'h15;
    cycle();
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; DbgAddr = 8'd0;
    op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0);
    op(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0044, 32'h0);
    chk("reset_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    chk("reset_alu", ALUResult_WB, 32'h0);
    Reset = 1'b0;

    // Give every RAM word a known value through the store path
    for (int w = 0; w < 256; w++) op(1'b0, 1'b1, 2'b11, 1'b0, 32'(w * 4), 32'h0);
    init_done = 1'b1;

    // 1: SW then LW
    DbgAddr = 8'd4;
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF);
    op(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk("lw_deadbeef", MemReadData_WB, 32'hDEAD_BEEF);

    // 2: byte store and signed/unsigned loads
    DbgAddr = 8'd8;
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_5680);
    op(1'b1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    chk("lb_signed", MemReadData_WB, 32'hFFFF_FF80);
    op(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    chk("lbu", MemReadData_WB, 32'h0000_0080);
    chk("sb_word8", DbgData, 32'h0000_8000);

    // 3: half store and loads
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_8001);
    op(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    chk("lh_signed", MemReadData_WB, 32'hFFFF_8001);
    op(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lhu", MemReadData_WB, 32'h0000_8001);
    chk("sh_word8", DbgData, 32'h8001_8000);

    // 4: stalled store lands once; flush blocks store and write-back
    DbgAddr = 8'd4;
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) op(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h1111_2222);
    chk("stall_hold_rdata", MemReadData_WB, 32'h0000_8001);
    chk("stall_no_write", DbgData, 32'hDEAD_BEEF);
    Stall = 1'b0;
    op(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h1111_2222);
    chk("stall_release_write", DbgData, 32'h1111_2222);
    Flush = 1'b1;
    op(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h3333_4444);
    chk("flush_regwrite", {31'd0, RegWrite_WB}, 32'd0);
    chk("flush_no_write", DbgData, 32'h1111_2222);
    Flush = 1'b0;
    op(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h5555_6666);
    chk("rmw_old_data", MemReadData_WB, 32'h1111_2222);
    chk("rmw_new_word", DbgData, 32'h5555_6666);

    // 5: reset mid-stream, memory kept, store suppressed
    op(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    Reset = 1'b1;
    op(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h7777_7777);
    chk("midreset_alu", ALUResult_WB, 32'h0);
    chk("midreset_pc", PCAdder_WB, 32'h0);
    chk("midreset_mem_kept", DbgData, 32'h5555_6666);
    Reset = 1'b0;

    // 6: misaligned word load
    op(1'b1, 1'b0, 2'b11, 1'b0, 32'h13, 32'h0);
`ifdef ALIGN_CHECK_EN
    chk("misalign_flag", {31'd0, MisAlign_WB}, 32'd1);
    chk("misalign_regwrite", {31'd0, RegWrite_WB}, 32'd0);
`else
    chk("forced_align_lw", MemReadData_WB, 32'h5555_6666);
`endif

    // Extra lanes, wrapping addresses and misaligned halves through the model
    DbgAddr = 8'hF0;
    op(1'b0, 1'b1, 2'b00, 1'b0, 32'hFFFF_F3C3, 32'h0000_00A5);
    op(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_03C1, 32'h0000_7F0E);
    op(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_03C0, 32'h0);
    op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_07C3, 32'h0);
    op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_03C2, 32'h0);
    op(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0123, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
